// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the scan generator and its axis counters.
package vga_timing_pkg;

  // Default raster timing (pixels / lines) and pixel-clock divider
  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Derived totals and sync windows [START, END)
  localparam int unsigned VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Coordinate and counter widths
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: wrap counter with enable, plus active-area and sync-window decode.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int unsigned W          = CNT_W,
  parameter int unsigned TOTAL      = VGA_H_TOTAL,
  parameter int unsigned ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned SYNC_START = VGA_H_SYNC_START,
  parameter int unsigned SYNC_END   = VGA_H_SYNC_END
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync_n
);

  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_LIM = W'(ACTIVE);
  localparam logic [W-1:0] SS     = W'(SYNC_START);
  localparam logic [W-1:0] SE     = W'(SYNC_END);

  // Count 0..TOTAL-1 on each enable, wrapping at the end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (en)
      count <= (count == LAST) ? '0 : count + W'(1);
  end

  // Wrap strobe and position decodes
  always_comb begin
    wrap   = en && (count == LAST);
    active = (count < ACT_LIM);
    sync_n = !((count >= SS) && (count < SE));
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan source: pixel divider, h/v counters, coordinate hand-off and registered DAC stage.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     rgb_r,
  input  logic [3:0]     rgb_g,
  input  logic [3:0]     rgb_b,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           video_on,
  output logic [3:0]     vga_r,
  output logic [3:0]     vga_g,
  output logic [3:0]     vga_b,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic           pix_tick,
  output logic           frame_tick
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap, h_active, v_active, hs_raw, vs_raw;
  logic             active;

  // Pixel-rate divider, wraps at CLK_DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      div <= '0;
    else if (div == DIV_LAST)
      div <= '0;
    else
      div <= div + DIV_W'(1);
  end

  // Gated by rst so the strobe reads 0 during reset even when CLK_DIV = 1
  always_comb begin
    pix_tick = rst && (div == DIV_LAST);
  end

  vga_axis_ctr #(
    .W          (CNT_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h_ctr (
    .clk    (clk),
    .rst    (rst),
    .en     (pix_tick),
    .count  (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync_n (hs_raw)
  );

  vga_axis_ctr #(
    .W          (CNT_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v_ctr (
    .clk    (clk),
    .rst    (rst),
    .en     (h_wrap),
    .count  (v_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync_n (vs_raw)
  );

  // Coordinates straight from the counters; v_wrap already implies pix_tick and h_wrap
  always_comb begin
    active     = h_active && v_active;
    x          = active ? X_W'(h_cnt) : '0;
    y          = active ? v_cnt[Y_W-1:0] : '0;
    frame_tick = v_wrap;
  end

  // Registered DAC stage, one pixel period behind x/y
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r    <= '0;
      vga_g    <= '0;
      vga_b    <= '0;
      vga_hs   <= 1'b1;
      vga_vs   <= 1'b1;
      video_on <= 1'b0;
    end else if (pix_tick) begin
      vga_r    <= active ? rgb_r : '0;
      vga_g    <= active ? rgb_g : '0;
      vga_b    <= active ? rgb_b : '0;
      vga_hs   <= hs_raw;
      vga_vs   <= vs_raw;
      video_on <= active;
    end
  end

endmodule
